// File: rtl/emu_ff_scan_ctrl.sv
// emu_ff_scan_ctrl
//   Checkpoint dump/restore sequencer for the emulated DUT's flip-flop scan
//   chain. A dump halts the DUT and rotates the chain once through the
//   out_* valid/ready source. A restore halts the DUT and loads the chain from
//   the in_* valid/ready sink. Shifting only happens on a handshake, so stream
//   backpressure freezes the chain in place.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for a command; halt follows the halt-hold flag
//   HALT    | one settle cycle with the DUT halted, no shifting
//   DUMP    | rotate chain, one beat per out_valid && out_ready
//   RESTORE | load chain, one beat per in_valid && in_ready
//   DONE    | one-cycle completion pulse, halt-hold flag updated
//
//   Ports
//     clk_i, rst_i                     clock, async active-high reset
//     cmd_valid_i/cmd_ready_o          command handshake
//     cmd_op_i (0 dump, 1 restore), cmd_beats_i, cmd_resume_i
//     done_o, busy_o                   completion pulse, activity flag
//     out_valid_o/out_ready_i/out_data_o   dump stream
//     in_valid_i/in_ready_o/in_data_i      restore stream
//     emu_halt_o, ff_scan_o, ff_dir_o, ff_sdi_o, ff_sdo_i   DUT scan port
module emu_ff_scan_ctrl #(
   parameter int DATA_WIDTH = 64,
   parameter int BEAT_W     = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic                  cmd_op_i,
   input  logic [BEAT_W-1:0]     cmd_beats_i,
   input  logic                  cmd_resume_i,
   output logic                  done_o,
   output logic                  busy_o,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [DATA_WIDTH-1:0] out_data_o,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [DATA_WIDTH-1:0] in_data_i,
   output logic                  emu_halt_o,
   output logic                  ff_scan_o,
   output logic                  ff_dir_o,
   output logic [DATA_WIDTH-1:0] ff_sdi_o,
   input  logic [DATA_WIDTH-1:0] ff_sdo_i
);

   typedef enum logic [2:0] {
      S_IDLE, S_HALT, S_DUMP, S_RESTORE, S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [BEAT_W-1:0] cnt_q, cnt_d;
   logic [BEAT_W-1:0] beats_q, beats_d;
   logic              op_q, op_d;
   logic              resume_q, resume_d;
   logic              zero_q, zero_d;   // current command had zero beats
   logic              hold_q, hold_d;   // keep DUT halted while idle

   logic              last_beat;

   // beats_q is never zero in DUMP/RESTORE, so beats_q-1 cannot underflow there
   assign last_beat = (cnt_q == beats_q - BEAT_W'(1));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         beats_q  <= '0;
         op_q     <= 1'b0;
         resume_q <= 1'b0;
         zero_q   <= 1'b0;
         hold_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         beats_q  <= beats_d;
         op_q     <= op_d;
         resume_q <= resume_d;
         zero_q   <= zero_d;
         hold_q   <= hold_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      beats_d  = beats_q;
      op_d     = op_q;
      resume_d = resume_q;
      zero_d   = zero_q;
      hold_d   = hold_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid_i) begin
               op_d     = cmd_op_i;
               beats_d  = cmd_beats_i;
               resume_d = cmd_resume_i;
               cnt_d    = '0;
               zero_d   = (cmd_beats_i == '0);
               state_d  = (cmd_beats_i == '0) ? S_DONE : S_HALT;
            end
         end
         S_HALT: state_d = op_q ? S_RESTORE : S_DUMP;
         S_DUMP: begin
            if (out_ready_i) begin
               cnt_d = cnt_q + BEAT_W'(1);
               if (last_beat) state_d = S_DONE;
            end
         end
         S_RESTORE: begin
            if (in_valid_i) begin
               cnt_d = cnt_q + BEAT_W'(1);
               if (last_beat) state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            if (!zero_q) hold_d = op_q & ~resume_q;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready_o = 1'b0;
      done_o      = 1'b0;
      busy_o      = (state_q != S_IDLE);
      out_valid_o = 1'b0;
      in_ready_o  = 1'b0;
      emu_halt_o  = 1'b1;
      ff_scan_o   = 1'b0;
      ff_dir_o    = 1'b0;
      ff_sdi_o    = '0;
      out_data_o  = ff_sdo_i;
      case (state_q)
         S_IDLE: begin
            cmd_ready_o = 1'b1;
            emu_halt_o  = hold_q;
         end
         S_HALT: ;
         S_DUMP: begin
            out_valid_o = 1'b1;
            ff_scan_o   = out_ready_i;
         end
         S_RESTORE: begin
            in_ready_o = 1'b1;
            ff_dir_o   = 1'b1;
            ff_sdi_o   = in_data_i;
            ff_scan_o  = in_valid_i;
         end
         S_DONE: begin
            done_o = 1'b1;
            // a zero-beat command never halted, so leave halt where it was
            if (zero_q) emu_halt_o = hold_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_emu_ff_scan_ctrl.sv
module tb_emu_ff_scan_ctrl;
   localparam int DW = 64;
   localparam int BW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid, cmd_ready, cmd_op, cmd_resume;
   logic [BW-1:0] cmd_beats;
   logic          done, busy;
   logic          out_valid, out_ready;
   logic [DW-1:0] out_data;
   logic          in_valid, in_ready;
   logic [DW-1:0] in_data;
   logic          emu_halt, ff_scan, ff_dir;
   logic [DW-1:0] ff_sdi, ff_sdo;

   always #5 clk = ~clk;

   emu_ff_scan_ctrl #(.DATA_WIDTH(DW), .BEAT_W(BW)) dut (
      .clk_i(clk), .rst_i(rst),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
      .cmd_beats_i(cmd_beats), .cmd_resume_i(cmd_resume),
      .done_o(done), .busy_o(busy),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
      .emu_halt_o(emu_halt), .ff_scan_o(ff_scan), .ff_dir_o(ff_dir),
      .ff_sdi_o(ff_sdi), .ff_sdo_i(ff_sdo)
   );

   // emulated scan chain: head word on ff_sdo, shift moves words toward head
   logic [DW-1:0] chain [8];
   logic [DW-1:0] golden [8];
   int            len = 3;
   assign ff_sdo = chain[0];

   always @(posedge clk) begin
      if (ff_scan) begin
         logic [DW-1:0] head;
         head = chain[0];
         for (int i = 0; i < len - 1; i++) chain[i] = chain[i+1];
         chain[len-1] = ff_dir ? ff_sdi : head;
      end
   end

   int acc_cnt = 0;
   always @(posedge clk) if (cmd_valid && cmd_ready) acc_cnt++;

   int n_chk = 0, n_pass = 0;
   bit exp_hold = 1'b0;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic scramble();
      for (int i = 0; i < 8; i++) chain[i] = {$urandom, $urandom};
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_cmd_ready"}, cmd_ready, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_in_ready"}, in_ready, 0);
      chk({tag, "_emu_halt"}, emu_halt, 0);
      chk({tag, "_ff_scan"}, ff_scan, 0);
      chk({tag, "_ff_dir"}, ff_dir, 0);
      chk({tag, "_ff_sdi"}, ff_sdi, 0);
   endtask

   // op 0 = dump (expects chain contents, rotates back), 1 = restore of golden
   task automatic do_cmd(input bit op, input int n, input bit resume, input bit rnd,
                         input bit hold_v, input int abort_at);
      int  k, cyc, acc0, exp_lat;
      bit  got_done, aborted;
      if (op == 1'b0) for (int i = 0; i < 8; i++) golden[i] = chain[i];
      if (n > 0) len = n;
      exp_lat = (n == 0) ? 1 : n + 2;
      acc0 = acc_cnt;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_beats = BW'(n); cmd_resume = resume;
      out_ready = 1'b0; in_valid = 1'b0;
      #1 chk("cmd_ready_idle", cmd_ready, 1);
      @(negedge clk);
      if (!hold_v) cmd_valid = 1'b0;
      k = 0; cyc = 0; got_done = 0; aborted = 0;
      while (cyc < 400 && !got_done) begin
         cyc++;
         if (abort_at > 0 && k == abort_at) begin
            rst = 1'b1;
            #1 chk_reset_outputs("abort");
            @(negedge clk);
            rst = 1'b0; cmd_valid = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
            exp_hold = 1'b0;
            aborted = 1;
            break;
         end
         if (op == 1'b0) out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         else begin
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = (in_valid && k < n) ? golden[k] : {$urandom, $urandom};
         end
         #1;
         if (done) begin
            got_done = 1;
            cmd_valid = 1'b0;
            if (!rnd) chk("latency", cyc, exp_lat);
            chk("done_busy", busy, 1);
            chk("done_cmd_ready", cmd_ready, 0);
            chk("done_scan", ff_scan, 0);
            chk("done_halt", emu_halt, (n == 0) ? exp_hold : 1'b1);
         end else begin
            chk("busy", busy, 1);
            chk("cmd_ready_busy", cmd_ready, 0);
            chk("halt_busy", emu_halt, 1);
            if (cyc == 1 && n > 0) begin
               chk("settle_scan", ff_scan, 0);
               chk("settle_oval", out_valid, 0);
               chk("settle_iready", in_ready, 0);
            end else if (op == 1'b0) begin
               chk("dump_oval", out_valid, 1);
               chk("dump_dir", ff_dir, 0);
               chk("dump_scan", ff_scan, out_ready);
               chk("dump_data", out_data, golden[k]);
               if (out_ready) k++;
            end else begin
               chk("rest_iready", in_ready, 1);
               chk("rest_dir", ff_dir, 1);
               chk("rest_scan", ff_scan, in_valid);
               chk("rest_sdi", ff_sdi, in_data);
               if (in_valid) k++;
            end
         end
         @(negedge clk);
      end
      out_ready = 1'b0; in_valid = 1'b0;
      if (aborted) return;
      if (!got_done) chk("done_timeout", 0, 1);
      chk("beats_moved", k, n);
      chk("accepts", acc_cnt - acc0, 1);
      for (int i = 0; i < n; i++) chk("chain_state", chain[i], golden[i]);
      if (n > 0) exp_hold = op & ~resume;
      #1;
      chk("idle_halt", emu_halt, exp_hold);
      chk("idle_cmd_ready", cmd_ready, 1);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 0; cmd_op = 0; cmd_beats = '0; cmd_resume = 0;
      out_ready = 0; in_valid = 0; in_data = '0;
      scramble();
      repeat (2) @(negedge clk);
      #1 chk_reset_outputs("reset");
      rst = 1'b0;

      // straight dump, then stalled dumps
      len = 3;
      do_cmd(0, 3, 0, 0, 0, 0);
      for (int r = 0; r < 3; r++) do_cmd(0, 3, 0, 1, 0, 0);

      // scramble then restore the dumped words, resume
      scramble();
      do_cmd(1, 3, 1, 1, 0, 0);

      // restore keeping halt, then a dump releases it
      scramble();
      do_cmd(1, 3, 0, 1, 0, 0);
      do_cmd(0, 3, 0, 0, 0, 0);

      // zero-beat commands with halt held and released
      do_cmd(1, 3, 0, 0, 0, 0);
      do_cmd(0, 0, 0, 0, 0, 0);
      do_cmd(0, 3, 0, 0, 0, 0);
      do_cmd(0, 0, 1, 0, 1, 0);

      // cmd_valid held through the whole command
      do_cmd(0, 3, 0, 1, 1, 0);

      // random commands
      for (int r = 0; r < 10; r++) begin
         bit op;
         int n;
         op = 1'($urandom_range(0, 1));
         n  = $urandom_range(1, 8);
         if (op) begin
            for (int i = 0; i < 8; i++) golden[i] = {$urandom, $urandom};
            scramble();
         end
         do_cmd(op, n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
      end

      // reset during dump beat 2, then a normal dump
      do_cmd(1, 3, 0, 0, 0, 0);
      do_cmd(0, 3, 0, 0, 0, 2);
      scramble();
      do_cmd(0, 3, 0, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
